// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the hazard scoreboard:
//   - FWD_REGFILE     : forwarding select value meaning "read the register file"
//   - entry_ctrl_t    : control fields of one tracker entry (valid/write/load)
//   - BUBBLE_CTRL     : control fields of an empty pipeline slot
//   - clog2()         : constant helper for deriving select widths
// The destination field width depends on the REG_AW parameter of the user, so
// it is kept beside the control struct rather than inside it.
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic v;   // slot holds a real instruction
        logic w;   // instruction writes a register
        logic m;   // instruction is a load
    } entry_ctrl_t;

    localparam entry_ctrl_t BUBBLE_CTRL = '{v: 1'b0, w: 1'b0, m: 1'b0};

    // Ceiling log2, never less than 1 so a select port is always at least 1 bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Combinational priority match of one source operand against the in-flight
// producers. The youngest matching producer wins; its position p yields the
// forwarding select p+1 (the position it will occupy next cycle). A match on a
// load that has not yet passed the memory stage raises load_hazard.
//
// Ports:
//   src          in  REG_AW           source register of the ID instruction
//   uses         in  1                ID instruction actually reads src
//   ctrl         in  (DEPTH-1) x ctrl control fields, positions 0..DEPTH-2
//   dest         in  (DEPTH-1) x REG_AW destination fields, same positions
//   sel          out SEL_W            forwarding select (0 = register file)
//   load_hazard  out 1                youngest match is a not-yet-ready load
// -----------------------------------------------------------------------------
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int DEPTH     = 3,
    parameter int MEM_STAGE = 1,
    parameter int SEL_W     = clog2(DEPTH + 1)
) (
    input  logic [REG_AW-1:0]                 src,
    input  logic                              uses,
    input  entry_ctrl_t [DEPTH-2:0]           ctrl,
    input  logic        [DEPTH-2:0][REG_AW-1:0] dest,
    output logic [SEL_W-1:0]                  sel,
    output logic                              load_hazard
);

    // NOTE: every output gets a default before the loop, so no path leaves
    // them unassigned and no latch is inferred.
    always_comb begin
        sel         = SEL_W'(FWD_REGFILE);
        load_hazard = 1'b0;
        // Walk oldest to youngest so the youngest match is the final write.
        for (int p = DEPTH - 2; p >= 0; p--) begin
            if (uses && (src != '0) && ctrl[p].v && ctrl[p].w && (dest[p] == src)) begin
                sel         = SEL_W'(p + 1);
                load_hazard = ctrl[p].m && ((p + 1) <= MEM_STAGE);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Hazard detection and forwarding controller for the pipelined MIPS datapath.
// Tracks destination registers of instructions in the post-decode stages,
// produces registered forwarding selects for the next EX cycle, a load-use
// stall and branch flush, and saturating counters of stall/flush cycles.
//
// Ports:
//   clock         in  1       system clock, rising edge
//   reset         in  1       synchronous active-high reset
//   id_valid      in  1       ID stage holds a real instruction
//   id_rs/id_rt   in  REG_AW  source registers A/B of the ID instruction
//   id_uses_rs/rt in  1       ID instruction reads rs/rt
//   id_reg_write  in  1       ID instruction writes a register
//   id_mem_read   in  1       ID instruction is a load
//   id_dest       in  REG_AW  ID destination register
//   branch_taken  in  1       branch resolved taken this cycle
//   stall         out 1       comb: hold PC and IF/ID, bubble into ID/EX
//   flush         out 1       comb: clear IF/ID (equals branch_taken)
//   fwd_a/fwd_b   out SEL_W   registered EX operand source, 0 = register file,
//                             k = result at tracker position k
//   stall_count   out CNT_W   saturating count of stall cycles
//   flush_count   out CNT_W   saturating count of flush cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int DEPTH     = 3,
    parameter int MEM_STAGE = 1,
    parameter int CNT_W     = 16,
    parameter int SEL_W     = clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              branch_taken,
    output logic              stall,
    output logic              flush,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    // Position DEPTH-1 is written back through the register file and is never
    // a forwarding candidate, so only positions 0..DEPTH-2 are held in flops.
    localparam int TRACK = DEPTH - 1;

    entry_ctrl_t [TRACK-1:0]             ctrl_q;
    logic        [TRACK-1:0][REG_AW-1:0] dest_q;

    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             haz_a;
    logic             haz_b;
    logic             issue;

    hazard_match #(
        .REG_AW    (REG_AW),
        .DEPTH     (DEPTH),
        .MEM_STAGE (MEM_STAGE),
        .SEL_W     (SEL_W)
    ) u_match_a (
        .src         (id_rs),
        .uses        (id_uses_rs),
        .ctrl        (ctrl_q),
        .dest        (dest_q),
        .sel         (sel_a),
        .load_hazard (haz_a)
    );

    hazard_match #(
        .REG_AW    (REG_AW),
        .DEPTH     (DEPTH),
        .MEM_STAGE (MEM_STAGE),
        .SEL_W     (SEL_W)
    ) u_match_b (
        .src         (id_rt),
        .uses        (id_uses_rt),
        .ctrl        (ctrl_q),
        .dest        (dest_q),
        .sel         (sel_b),
        .load_hazard (haz_b)
    );

    // A taken branch squashes the ID instruction, so it overrides any stall.
    assign stall = id_valid & (haz_a | haz_b) & ~branch_taken;
    assign flush = branch_taken;
    assign issue = id_valid & ~stall & ~branch_taken;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, which the tracker shift relies on.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the tracker is reset too: stale valid bits would raise
            // phantom stalls and forwards after reset.
            ctrl_q      <= '0;
            dest_q      <= '0;
            fwd_a       <= SEL_W'(FWD_REGFILE);
            fwd_b       <= SEL_W'(FWD_REGFILE);
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            ctrl_q[0] <= issue ? '{v: 1'b1, w: id_reg_write, m: id_mem_read} : BUBBLE_CTRL;
            dest_q[0] <= issue ? id_dest : '0;
            for (int i = 1; i < TRACK; i++) begin
                ctrl_q[i] <= ctrl_q[i-1];
                dest_q[i] <= dest_q[i-1];
            end

            // A bubble entering EX must read the register file.
            fwd_a <= issue ? sel_a : SEL_W'(FWD_REGFILE);
            fwd_b <= issue ? sel_b : SEL_W'(FWD_REGFILE);

            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (branch_taken && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard-detection and forwarding controller for the pipelined MIPS datapath.
- Tracks in-flight destination registers across DEPTH post-decode stages (position 0 = EX, position DEPTH-1 = last write-back-capable stage).
- From the ID-stage operands it produces:
  - registered forwarding selects for the following EX cycle;
  - a load-use stall;
  - branch-flush bubbles.
- Replaces the two-source fixed forwarding unit with arbitrary pipeline depth, configurable memory-stage position, and saturating stall/flush counters.

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, tracked stages after ID (EX, MEM, WB); must be >= 2.
- MEM_STAGE, 1, tracker position of the data-memory stage. Load results are forwardable only from positions > MEM_STAGE.
- CNT_W, 16, width of the statistic counters.
- SEL_W, clog2(DEPTH+1), forwarding select width (derived; do not override).

Ports:
- clock in 1 system clock, rising edge.
- reset in 1 synchronous, active-high; clears all state at the next edge.
- id_valid in 1 ID stage holds a real instruction.
- id_rs in REG_AW source register A of the ID instruction.
- id_rt in REG_AW source register B of the ID instruction.
- id_uses_rs in 1 ID instruction reads rs.
- id_uses_rt in 1 ID instruction reads rt.
- id_reg_write in 1 ID instruction writes a register.
- id_mem_read in 1 ID instruction is a load.
- id_dest in REG_AW ID destination register (after the regDest mux).
- branch_taken in 1 branch resolved taken this cycle.
- stall out 1 combinational; hold PC and IF/ID, insert bubble into ID/EX.
- flush out 1 combinational; equals branch_taken; clear IF/ID.
- fwd_a out SEL_W registered EX operand-A source: 0 = register file, k = result at stage position k.
- fwd_b out SEL_W same as fwd_a, for operand B.
- stall_count out CNT_W saturating count of stall cycles.
- flush_count out CNT_W saturating count of flush cycles.

Behaviour:
- Tracker: DEPTH entries. Each entry holds:
  - v: valid;
  - w: writes a register;
  - m: load;
  - d: destination, REG_AW bits.
- Every edge:
  - entry[i] <= entry[i-1] for i = 1..DEPTH-1;
  - entry[0] <= ID instruction if id_valid & ~stall & ~branch_taken, otherwise bubble (all fields 0).
- Producer match at position p, for source s: entry[p].v & entry[p].w & entry[p].d == s & s != 0 & the matching uses_* bit is set.
  - Register 0 never matches.
- Candidate source for next cycle is p+1. Only p in 0..DEPTH-2 is considered; position DEPTH-1 is assumed written back through the register file.
- Youngest (lowest p) match wins per operand. No match gives select 0.
- Load-use hazard: youngest match has m=1 and p+1 <= MEM_STAGE. This asserts stall that cycle, for either operand.
  - Defaults give a one-cycle stall for load followed by a dependent instruction.
  - Larger MEM_STAGE gives multi-cycle stalls. These resolve naturally because the producer advances while bubbles are inserted.
- fwd_a/fwd_b register the computed selects when ~stall & ~branch_taken & id_valid. Otherwise they register 0, so a bubble in EX uses the register file.
- Simultaneous branch_taken and hazard: branch wins.
  - stall = 0, flush = 1, bubble inserted.
  - flush_count increments; stall_count does not.
- Counters:
  - stall_count increments on each cycle with stall = 1;
  - flush_count increments on each cycle with branch_taken = 1;
  - both hold at 2^CNT_W-1 (no wrap).
- Reset values: all tracker entries invalid; fwd_a = fwd_b = 0; both counters 0.
  - stall = 0 and flush = branch_taken (combinational).
  - Reset mid-stall: stall deasserts in the cycle after the reset edge.
- Inputs with id_valid = 0 are ignored (no stall, no entry).

Decomposition:
- Shared package hazard_pkg:
  - FWD_REGFILE = 0;
  - struct/localparams for the tracker entry fields;
  - clog2 helper function.
- Sub-module hazard_match: combinational per-operand priority match. Takes the source register, the uses bit and the tracker vector; returns the select and a load-hazard flag. It is instantiated twice, once for rs and once for rt.

Test Plan:
- add r3 (reg_write, dest 3), then a dependent instruction with rs = 3 → no stall; fwd_a = 1 in the EX cycle of the dependent; fwd_b = 0.
- Producer of r5, one unrelated instruction, then rt = 5 → fwd_b = 2; no stall.
- lw r4, then rs = 4 → stall = 1 for exactly 1 cycle and stall_count = 1. Next cycle: stall = 0 and fwd_a = 2.
- Writer of r0 followed by a reader of r0 → fwd = 0, no stall. Two writers of r7 back-to-back, then a reader → fwd = 1 (youngest).
- lw r4, dependent instruction, with branch_taken asserted the same cycle → stall = 0, flush = 1, flush_count = 1, next fwd = 0. Repeat with MEM_STAGE = 2 → a 2-cycle stall.
- Reset asserted during a stall; also drive 2^CNT_W+3 stall cycles with CNT_W = 4 → after reset all outputs are 0. The counter saturates at 15.
